// File: rtl/led_mode_ctrl_if.sv
// ---------------------------------------------------------------------------
// led_mode_if
//
// Board-facing signal bundle for the LED mode controller.
//
//   btn  [4:0]  raw push buttons, active-high, asynchronous to clk
//   sw   [7:0]  slide switches, quasi-static
//   ledr [15:0] LED bus: {4'b0, dir, paused, mode, display byte}
//   mode [1:0]  current display mode
//
// Modports:
//   master - board / stimulus side: drives btn and sw, observes the LEDs
//   slave  - controller side: reads btn and sw, drives ledr and mode
// ---------------------------------------------------------------------------
interface led_mode_if;
    logic [4:0]  btn;
    logic [7:0]  sw;
    logic [15:0] ledr;
    logic [1:0]  mode;

    modport master (
        output btn,
        output sw,
        input  ledr,
        input  mode
    );

    modport slave (
        input  btn,
        input  sw,
        output ledr,
        output mode
    );
endinterface

// File: rtl/led_mode_ctrl.sv
// ---------------------------------------------------------------------------
// led_mode_ctrl
//
// Mode controller for the 8-bit LED bank. Debounces five push buttons into
// one-cycle press events, steps an 8-bit display pattern through four modes
// (ROTATE, BLINK, COUNT, MIRROR) at a programmable tick rate, and drives the
// 16-bit LED bus with pattern, mode and status.
//
// Parameters:
//   TICK_DIV  - clock cycles per pattern tick (>= 2)
//   DB_CYCLES - consecutive stable samples needed to accept a level change
//               on a button (>= 2)
//
// Ports:
//   clk  in   system clock
//   rst  in   asynchronous, active-high reset
//   bus  slave modport of led_mode_if (btn, sw in; ledr, mode out)
//
// Button map: [0] NEXT mode, [1] PREV mode, [2] PAUSE toggle,
//             [3] DIR toggle, [4] CLEAR (reload current mode's pattern).
// ---------------------------------------------------------------------------
module led_mode_ctrl #(
    parameter int TICK_DIV  = 5000000,
    parameter int DB_CYCLES = 50000
) (
    input  logic       clk,
    input  logic       rst,
    led_mode_if.slave  bus
);

    localparam int DCW = (DB_CYCLES > 2) ? $clog2(DB_CYCLES) : 1;
    localparam int TCW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;

    localparam logic [DCW-1:0] DB_LAST   = DCW'(DB_CYCLES - 1);
    localparam logic [TCW-1:0] TICK_LAST = TCW'(TICK_DIV - 1);

    localparam int BTN_NEXT  = 0;
    localparam int BTN_PREV  = 1;
    localparam int BTN_PAUSE = 2;
    localparam int BTN_DIR   = 3;
    localparam int BTN_CLEAR = 4;

    typedef enum logic [1:0] {
        MODE_ROTATE = 2'd0,
        MODE_BLINK  = 2'd1,
        MODE_COUNT  = 2'd2,
        MODE_MIRROR = 2'd3
    } mode_t;

    // Pattern loaded whenever a mode is entered or cleared.
    function automatic logic [7:0] init_pat(input mode_t m);
        return (m == MODE_ROTATE) ? 8'h01 : 8'h00;
    endfunction

    // -----------------------------------------------------------------------
    // Two-flop synchronizer for the raw buttons
    // -----------------------------------------------------------------------
    logic [4:0] s1_reg;
    logic [4:0] s2_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_reg <= '0;
            s2_reg <= '0;
        end else begin
            s1_reg <= bus.btn;
            s2_reg <= s1_reg;
        end
    end

    // -----------------------------------------------------------------------
    // Per-button debounce: the debounced level only follows s2 after it has
    // differed for DB_CYCLES consecutive samples. Any sample that agrees with
    // the current level restarts the count, so short glitches are dropped.
    // -----------------------------------------------------------------------
    logic [4:0] db;

    for (genvar gi = 0; gi < 5; gi++) begin : g_db
        logic [DCW-1:0] dcnt_reg;
        logic           db_bit_reg;

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                dcnt_reg   <= '0;
                db_bit_reg <= 1'b0;
            end else if (s2_reg[gi] == db_bit_reg) begin
                dcnt_reg   <= '0;
            end else if (dcnt_reg == DB_LAST) begin
                db_bit_reg <= s2_reg[gi];
                dcnt_reg   <= '0;
            end else begin
                dcnt_reg   <= dcnt_reg + DCW'(1);
            end
        end

        assign db[gi] = db_bit_reg;
    end

    // Rising edge of the debounced level is the press event; releases are
    // intentionally silent.
    logic [4:0] db_d_reg;
    logic [4:0] ev;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            db_d_reg <= '0;
        end else begin
            db_d_reg <= db;
        end
    end

    assign ev = db & ~db_d_reg;

    // -----------------------------------------------------------------------
    // Mode / pattern state
    // -----------------------------------------------------------------------
    mode_t          mode_reg,   mode_next;
    logic [7:0]     pat_reg,    pat_next;
    logic [TCW-1:0] div_reg,    div_next;
    logic           paused_reg, paused_next;
    logic           dir_reg,    dir_next;

    logic tick;
    logic reload;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mode_reg   <= MODE_ROTATE;
            pat_reg    <= 8'h01;
            div_reg    <= '0;
            paused_reg <= 1'b0;
            dir_reg    <= 1'b0;
        end else begin
            mode_reg   <= mode_next;
            pat_reg    <= pat_next;
            div_reg    <= div_next;
            paused_reg <= paused_next;
            dir_reg    <= dir_next;
        end
    end

    always_comb begin
        mode_next   = mode_reg;
        pat_next    = pat_reg;
        div_next    = div_reg;
        paused_next = paused_reg ^ ev[BTN_PAUSE];
        dir_next    = dir_reg ^ ev[BTN_DIR];

        tick   = ~paused_reg & (div_reg == TICK_LAST);
        reload = ev[BTN_CLEAR] | ev[BTN_NEXT] | ev[BTN_PREV];

        // CLEAR outranks NEXT, which outranks PREV; CLEAR keeps the mode.
        if (ev[BTN_CLEAR]) begin
            mode_next = mode_reg;
        end else if (ev[BTN_NEXT]) begin
            mode_next = mode_t'(mode_reg + 2'd1);
        end else if (ev[BTN_PREV]) begin
            mode_next = mode_t'(mode_reg - 2'd1);
        end

        if (reload) begin
            // A reload swallows any tick landing on the same edge.
            pat_next = init_pat(mode_next);
            div_next = '0;
        end else begin
            if (!paused_reg) begin
                div_next = (div_reg == TICK_LAST) ? '0 : div_reg + TCW'(1);
            end

            if (tick) begin
                case (mode_reg)
                    MODE_ROTATE: pat_next = dir_reg ? {pat_reg[0], pat_reg[7:1]}
                                                    : {pat_reg[6:0], pat_reg[7]};
                    MODE_BLINK:  pat_next = (pat_reg == 8'h00) ? bus.sw : 8'h00;
                    MODE_COUNT:  pat_next = dir_reg ? pat_reg - 8'd1 : pat_reg + 8'd1;
                    MODE_MIRROR: pat_next = pat_reg;
                    default:     pat_next = pat_reg;
                endcase
            end
        end
    end

    // -----------------------------------------------------------------------
    // Outputs: everything is straight from registers except the low byte in
    // MIRROR, which is a deliberate combinational path from the switches.
    // -----------------------------------------------------------------------
    logic [7:0] display;

    always_comb begin
        display = pat_reg;
        if (mode_reg == MODE_MIRROR) begin
            display = bus.sw;
        end
    end

    assign bus.ledr = {4'b0000, dir_reg, paused_reg, mode_reg, display};
    assign bus.mode = mode_reg;

endmodule

// File: tb/tb_led_mode_ctrl.sv
module tb_led_mode_ctrl;

    localparam int TICK_DIV  = 4;
    localparam int DB_CYCLES = 3;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    led_mode_if bus ();

    led_mode_ctrl #(
        .TICK_DIV  (TICK_DIV),
        .DB_CYCLES (DB_CYCLES)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        string       tag;
        logic [17:0] val;
    } exp_t;

    exp_t sb_q[$];
    int   n_cmp  = 0;
    int   n_fail = 0;
    int   cyc    = 0;

    // Expected {mode, ledr}
    function automatic logic [17:0] ex(input logic [1:0] m, input logic d,
                                       input logic p, input logic [7:0] b);
        return {m, 4'b0000, d, p, m, b};
    endfunction

    // ROTATE pattern c edges after reset release (dir=0, no reloads)
    function automatic logic [7:0] rot(input int c);
        return 8'(1 << ((c / 4) % 8));
    endfunction

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            cyc++;
        end
        #1;
    endtask

    task automatic expect_val(input string tag, input logic [17:0] v);
        exp_t e;
        e.tag = tag;
        e.val = v;
        sb_q.push_back(e);
    endtask

    task automatic check_out();
        exp_t        e;
        logic [17:0] obs;
        obs = {bus.mode, bus.ledr};
        n_cmp++;
        if (sb_q.size() == 0) begin
            n_fail++;
            $error("FAIL scoreboard_empty observed=%h expected=none", obs);
        end else begin
            e = sb_q.pop_front();
            $display("check %-14s observed=%h expected=%h", e.tag, obs, e.val);
            assert (obs === e.val) else begin
                n_fail++;
                $error("FAIL %s observed=%h expected=%h", e.tag, obs, e.val);
            end
        end
    endtask

    // Hold buttons for 6 edges (command lands on the 6th), release, then
    // idle 6 edges so the release finishes debouncing.
    task automatic press(input logic [4:0] m, input string tag,
                         input logic [17:0] e1, input logic [17:0] e2);
        bus.btn = m;
        expect_val(tag, e1);
        step(6);
        check_out();
        bus.btn = 5'b0;
        expect_val({tag, "_idle"}, e2);
        step(6);
        check_out();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        logic [7:0] p;
        logic       d;
        logic       ps;

        rst     = 1'b1;
        bus.btn = 5'b0;
        bus.sw  = 8'h00;
        expect_val("reset", ex(2'd0, 1'b0, 1'b0, 8'h01));
        step(2);
        check_out();

        rst = 1'b0;
        cyc = 0;

        // ROTATE from reset: one step every 4 edges, full circle in 32
        for (int j = 1; j <= 32; j++) begin
            expect_val("rotate", ex(2'd0, 1'b0, 1'b0, rot(j)));
            step(1);
            check_out();
        end

        // 2-cycle glitch on NEXT: no mode change
        bus.btn = 5'b00001;
        for (int j = 1; j <= 12; j++) begin
            expect_val("glitch", ex(2'd0, 1'b0, 1'b0, rot(cyc + 1)));
            step(1);
            check_out();
            if (j == 2) bus.btn = 5'b0;
        end

        // NEXT held 8 cycles: mode 1 on 6th edge (edge 5 after first sample)
        bus.btn = 5'b00001;
        for (int j = 1; j <= 8; j++) begin
            if (j < 6) expect_val("hold_next", ex(2'd0, 1'b0, 1'b0, rot(cyc + 1)));
            else       expect_val("hold_next", ex(2'd1, 1'b0, 1'b0, 8'h00));
            step(1);
            check_out();
            if (j == 8) begin
                bus.btn = 5'b0;
                bus.sw  = 8'hA5;
            end
        end

        // BLINK: first tick 2 edges from here, then every 4
        for (int k = 1; k <= 16; k++) begin
            p = (((k + 2) / 4) % 2) != 0 ? 8'hA5 : 8'h00;
            expect_val("blink", ex(2'd1, 1'b0, 1'b0, p));
            step(1);
            check_out();
        end

        // Enter COUNT
        bus.btn = 5'b00001;
        expect_val("next_to_count", ex(2'd2, 1'b0, 1'b0, 8'h00));
        step(6);
        check_out();
        bus.btn = 5'b0;

        // Count up to 3, DIR lands between ticks, then 2,1,0,FF
        for (int j = 1; j <= 28; j++) begin
            p = (j < 16) ? 8'(j / 4) : 8'(6 - j / 4);
            d = (j >= 13);
            expect_val("count_dir", ex(2'd2, d, 1'b0, p));
            step(1);
            check_out();
            if (j == 7)  bus.btn = 5'b01000;
            if (j == 13) bus.btn = 5'b0;
        end

        // PAUSE: one more tick lands before pause takes hold, then frozen
        bus.btn = 5'b00100;
        for (int j = 1; j <= 26; j++) begin
            p  = (j < 4) ? 8'hFF : 8'hFE;
            ps = (j >= 6);
            expect_val("pause", ex(2'd2, 1'b1, ps, p));
            step(1);
            check_out();
            if (j == 6) bus.btn = 5'b0;
        end

        // Mode walk while paused; PREV wraps 0 -> 3
        press(5'b00001, "next_mirror", ex(2'd3, 1'b1, 1'b1, 8'hA5), ex(2'd3, 1'b1, 1'b1, 8'hA5));
        press(5'b00001, "next_wrap",   ex(2'd0, 1'b1, 1'b1, 8'h01), ex(2'd0, 1'b1, 1'b1, 8'h01));
        press(5'b00010, "prev_wrap",   ex(2'd3, 1'b1, 1'b1, 8'hA5), ex(2'd3, 1'b1, 1'b1, 8'hA5));

        // MIRROR follows sw without a clock edge
        bus.sw = 8'h3C;
        expect_val("mirror_live", ex(2'd3, 1'b1, 1'b1, 8'h3C));
        #1;
        check_out();

        // NEXT+PREV together: +1 only
        press(5'b00011, "next_prev_a", ex(2'd0, 1'b1, 1'b1, 8'h01), ex(2'd0, 1'b1, 1'b1, 8'h01));
        press(5'b00011, "next_prev_b", ex(2'd1, 1'b1, 1'b1, 8'h00), ex(2'd1, 1'b1, 1'b1, 8'h00));
        press(5'b00011, "next_prev_c", ex(2'd2, 1'b1, 1'b1, 8'h00), ex(2'd2, 1'b1, 1'b1, 8'h00));

        // Unpause in COUNT (dir=1): one down-tick during idle
        press(5'b00100, "unpause",     ex(2'd2, 1'b1, 1'b0, 8'h00), ex(2'd2, 1'b1, 1'b0, 8'hFF));

        // CLEAR+NEXT: mode kept, reload beats the coinciding tick
        press(5'b10001, "clear_next",  ex(2'd2, 1'b1, 1'b0, 8'h00), ex(2'd2, 1'b1, 1'b0, 8'hFF));

        // Async reset mid-debounce
        bus.btn = 5'b00001;
        step(3);
        rst = 1'b1;
        expect_val("async_reset", ex(2'd0, 1'b0, 1'b0, 8'h01));
        #1;
        check_out();
        bus.btn = 5'b0;
        step(2);
        rst = 1'b0;
        cyc = 0;
        expect_val("post_reset", ex(2'd0, 1'b0, 1'b0, 8'h04));
        step(10);
        check_out();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
